serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Receive-side counterpart to a per-cycle bit stimulus (d qualified by en).
- Deserializes framed serial bits into parallel words:
  - start bit = 1,
  - WIDTH data bits, LSB first,
  - optional even-parity bit.
- Presents each word on a valid/ready output register.
- Sits downstream of a bit-level driver or flop chain; feeds word-level consumers.

Parameters:
- WIDTH, 8, data bits per frame (legal range 2..32).
- PARITY_EN, 1, 1 = frame carries a trailing even-parity bit; 0 = no parity bit.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  serial bit qualifier; d is sampled only when en=1.
- d  input  1  serial data bit.
- out_data  output  WIDTH  received word.
- out_perr  output  1  parity error for out_data (always 0 when PARITY_EN=0).
- out_valid  output  1  out_data/out_perr hold a word.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready.
- overrun  output  1  sticky: a completed word was dropped.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at posedge), regardless of state:
  - FSM to IDLE, bit counter 0, shift register 0.
  - out_data 0, out_perr 0, out_valid 0, overrun 0, busy 0.
  - Reset mid-frame discards the partial frame.
- Cycles with en=0: FSM, counter and shift register hold. The output handshake still operates.
- FSM states IDLE, DATA, PARITY:
  - IDLE: en & d=1 -> DATA, counter=0. en & d=0 -> stay in IDLE (line idle).
  - DATA: each en cycle shifts d into bit position counter (LSB first) and increments counter.
    - On the en cycle where counter==WIDTH-1: go to PARITY if PARITY_EN, else complete the word and go to IDLE.
  - PARITY: on the next en cycle, sample the parity bit; perr = XOR(data bits, parity bit). Complete the word and go to IDLE.
- Word completion:
  - out_data/out_perr load and out_valid=1 on the same posedge as the final bit is sampled.
  - Latency: visible the cycle after the final bit is presented.
- Handshake:
  - out_valid stays 1 and out_data stays stable until out_valid & out_ready at a posedge; then out_valid=0 unless a new word completes in that same cycle.
  - Simultaneous consume and complete: the new word loads and out_valid stays 1 (no bubble, no drop).
  - Completion while out_valid=1 & out_ready=0: the new word is dropped, the held word is unchanged, overrun=1.
- overrun clears only on rst.
- busy = (state != IDLE).
- Back-to-back frames: a start bit may arrive on the en cycle immediately after the final bit; no idle gap is required.
- Counter width: clog2(WIDTH); no wrap beyond WIDTH-1.

Decomposition:
- Package serial_frame_pkg holds:
  - typedef enum rx_state_e {IDLE, DATA, PARITY},
  - a helper function for even parity.
- Sub-module serial_out_reg: the one-entry valid/ready output register with the overrun flag. Its load/consume/drop rules are isolated there for separate unit testing.
- The FSM and shift register stay in the top module.

Test Plan:
- Reset, then frame with en=1 every cycle: bits 1, 0xA5 LSB first (1,0,1,0,0,1,0,1), parity 0, out_ready=1 -> out_data=0xA5, out_perr=0, out_valid high exactly 1 cycle.
- Same frame with parity bit 1 -> out_data=0xA5, out_perr=1.
- Same frame with en toggling 1,0,1,0 and d=1 on the en=0 cycles -> out_data=0xA5; bits sampled on en=0 cycles are ignored.
- out_ready=0, send 0x3C then 0xC3 -> out_data stays 0x3C, overrun=1. Then out_ready=1 -> out_valid=0 the next cycle; overrun stays 1.
- Word held, out_ready raised on the same cycle the next frame's parity bit is sampled (0x3C then 0x11) -> out_valid stays 1, out_data=0x11, overrun=0.
- rst=1 after 4 data bits, then a full 0x0F frame -> out_data=0x0F, no stale bits, busy=0 right after rst. Also PARITY_EN=0 build: 0x0F frame completes after bit 8, out_perr=0.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } rx_state_e;

    // Even parity across up to 32 bits; narrower words are zero-extended by the caller.
    function automatic logic even_par(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// Word-level valid/ready output bus of the receiver.
interface serial_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] out_data;
    logic             out_perr;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data,
        output out_perr,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_perr,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/serial_frame_rx_out_reg.sv
// One-entry valid/ready output register with sticky overrun flag.
module serial_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_perr,
    serial_frame_rx_if.master obus,
    output logic             overrun
);

    logic consume;
    assign consume = obus.out_valid & obus.out_ready;

    // Load when empty or draining this cycle; otherwise a completed word is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            obus.out_data  <= '0;
            obus.out_perr  <= 1'b0;
            obus.out_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (load && (!obus.out_valid || obus.out_ready)) begin
                obus.out_data  <= load_data;
                obus.out_perr  <= load_perr;
                obus.out_valid <= 1'b1;
            end else if (consume) begin
                obus.out_valid <= 1'b0;
            end
            if (load && obus.out_valid && !obus.out_ready)
                overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits LSB first, optional even parity.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    serial_frame_rx_if.master obus,
    output logic overrun,
    output logic busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rx_state_e        state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic             load, load_perr;

    // State, bit counter and shift register; all hold when en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
        end
    end

    // Next-state, bit capture and word-completion strobe.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        load      = 1'b0;
        load_perr = 1'b0;
        if (en) begin
            unique case (state)
                IDLE: begin
                    if (d) begin
                        state_n = DATA;
                        cnt_n   = '0;
                        sh_n    = '0;
                    end
                end
                DATA: begin
                    sh_n[cnt] = d;
                    if (cnt == LAST) begin
                        cnt_n = '0;
                        if (PARITY_EN) begin
                            state_n = PARITY;
                        end else begin
                            state_n = IDLE;
                            load    = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                PARITY: begin
                    load      = 1'b1;
                    load_perr = even_par(32'(sh)) ^ d;
                    state_n   = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    serial_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (sh_n),
        .load_perr (load_perr),
        .obus      (obus),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: parity and no-parity builds side by side, scoreboarded outputs.
module tb_serial_frame_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en0 = 1'b0, d0 = 1'b0, en1 = 1'b0, d1 = 1'b0;
    logic ov0, ov1, busy0, busy1;

    always #5 clk = ~clk;

    serial_frame_rx_if #(.WIDTH(8)) ob0 ();
    serial_frame_rx_if #(.WIDTH(8)) ob1 ();

    serial_frame_rx #(.WIDTH(8), .PARITY_EN(1)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .d(d0), .obus(ob0), .overrun(ov0), .busy(busy0)
    );
    serial_frame_rx #(.WIDTH(8), .PARITY_EN(0)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .d(d1), .obus(ob1), .overrun(ov1), .busy(busy1)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } word_t;

    word_t q0[$], q1[$];
    word_t w0, w1;
    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // Every accepted word must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && ob0.out_valid && ob0.out_ready) begin
            if (q0.size() == 0) chk("q0_underflow", q0.size(), 1);
            else begin
                w0 = q0.pop_front();
                chk("d0_data", ob0.out_data, w0.data);
                chk("d0_perr", ob0.out_perr, w0.perr);
            end
        end
        if (!rst && ob1.out_valid && ob1.out_ready) begin
            if (q1.size() == 0) chk("q1_underflow", q1.size(), 1);
            else begin
                w1 = q1.pop_front();
                chk("d1_data", ob1.out_data, w1.data);
                chk("d1_perr", ob1.out_perr, w1.perr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit sel, input logic b);
        if (sel) begin en1 = 1'b1; d1 = b; end
        else     begin en0 = 1'b1; d0 = b; end
        tick();
    endtask

    task automatic gap(input bit sel);
        if (sel) begin en1 = 1'b0; d1 = 1'b1; end
        else     begin en0 = 1'b0; d0 = 1'b1; end
        tick();
    endtask

    task automatic idle(input bit sel);
        if (sel) begin en1 = 1'b0; d1 = 1'b0; end
        else     begin en0 = 1'b0; d0 = 1'b0; end
    endtask

    // Drives one frame; returns right after the posedge that samples the final bit.
    task automatic send(input bit sel, input logic [7:0] v, input logic pbit,
                        input bit gaps, input bit rdy_par);
        drive_bit(sel, 1'b1);
        if (gaps) gap(sel);
        for (int i = 0; i < 8; i++) begin
            drive_bit(sel, v[i]);
            if (gaps && !(sel && i == 7)) gap(sel);
        end
        if (!sel) begin
            if (rdy_par) ob0.out_ready = 1'b1;
            drive_bit(sel, pbit);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        ob0.out_ready = 1'b0;
        ob1.out_ready = 1'b0;
        repeat (2) tick();
        chk("rst_valid0", ob0.out_valid, 0);
        chk("rst_data0",  ob0.out_data,  0);
        chk("rst_perr0",  ob0.out_perr,  0);
        chk("rst_ov0",    ov0,           0);
        chk("rst_busy0",  busy0,         0);
        chk("rst_valid1", ob1.out_valid, 0);
        chk("rst_busy1",  busy1,         0);
        rst = 1'b0;
        tick();

        // Clean frame, continuous en; valid must last exactly one cycle.
        ob0.out_ready = 1'b1;
        q0.push_back('{8'hA5, 1'b0});
        send(0, 8'hA5, 1'b0, 0, 0);
        idle(0);
        chk("a5_valid", ob0.out_valid, 1);
        chk("a5_data",  ob0.out_data,  8'hA5);
        chk("a5_busy",  busy0,         0);
        tick();
        chk("a5_valid_1cyc", ob0.out_valid, 0);

        // Wrong parity bit.
        q0.push_back('{8'hA5, 1'b1});
        send(0, 8'hA5, 1'b1, 0, 0);
        idle(0);
        chk("perr_flag", ob0.out_perr, 1);
        tick();

        // en toggling, d=1 on the gaps must be ignored.
        q0.push_back('{8'hA5, 1'b0});
        send(0, 8'hA5, 1'b0, 1, 0);
        idle(0);
        chk("gap_data", ob0.out_data, 8'hA5);
        chk("gap_perr", ob0.out_perr, 0);
        tick();

        // Back-to-back frames with no idle gap.
        q0.push_back('{8'hA5, 1'b0});
        q0.push_back('{8'h5A, 1'b0});
        send(0, 8'hA5, 1'b0, 0, 0);
        send(0, 8'h5A, 1'b0, 0, 0);
        idle(0);
        chk("b2b_data", ob0.out_data, 8'h5A);
        repeat (2) tick();

        // Overrun: second word dropped while the first is held.
        pulse_rst();
        ob0.out_ready = 1'b0;
        q0.push_back('{8'h3C, 1'b0});
        send(0, 8'h3C, 1'b0, 0, 0);
        idle(0);
        tick();
        send(0, 8'hC3, 1'b0, 0, 0);
        idle(0);
        chk("ovr_valid", ob0.out_valid, 1);
        chk("ovr_data",  ob0.out_data,  8'h3C);
        chk("ovr_flag",  ov0,           1);
        ob0.out_ready = 1'b1;
        tick();
        chk("ovr_drain_valid", ob0.out_valid, 0);
        chk("ovr_sticky",      ov0,           1);

        // Consume and complete in the same cycle: no bubble, no drop.
        pulse_rst();
        chk("rst_clears_ov", ov0, 0);
        ob0.out_ready = 1'b0;
        q0.push_back('{8'h3C, 1'b0});
        send(0, 8'h3C, 1'b0, 0, 0);
        idle(0);
        tick();
        q0.push_back('{8'h11, 1'b0});
        send(0, 8'h11, 1'b0, 0, 1);
        idle(0);
        chk("sim_valid", ob0.out_valid, 1);
        chk("sim_data",  ob0.out_data,  8'h11);
        chk("sim_ov",    ov0,           0);
        tick();
        chk("sim_drain", ob0.out_valid, 0);

        // Reset mid-frame discards the partial frame.
        drive_bit(0, 1'b1);
        for (int i = 0; i < 4; i++) drive_bit(0, 1'b1);
        idle(0);
        chk("mid_busy", busy0, 1);
        pulse_rst();
        chk("mid_rst_busy",  busy0,         0);
        chk("mid_rst_valid", ob0.out_valid, 0);
        q0.push_back('{8'h0F, 1'b0});
        send(0, 8'h0F, 1'b0, 0, 0);
        idle(0);
        chk("mid_data", ob0.out_data, 8'h0F);
        tick();

        // No-parity build completes on the last data bit.
        ob1.out_ready = 1'b1;
        q1.push_back('{8'h0F, 1'b0});
        send(1, 8'h0F, 1'b0, 0, 0);
        idle(1);
        chk("np_valid", ob1.out_valid, 1);
        chk("np_data",  ob1.out_data,  8'h0F);
        chk("np_perr",  ob1.out_perr,  0);
        chk("np_busy",  busy1,         0);
        tick();
        chk("np_valid_1cyc", ob1.out_valid, 0);

        repeat (3) tick();
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
